vga_sprite_render: RTL

Pixel-colour stage directly downstream of the 640x480@60 VGA timing generator. It consumes the pixel counters, video_on, hsync and vsync, and draws two player rectangles and a ground band over a background colour. Its outputs drive the DAC/connector pins. It re-times the syncs so that colour and sync leave the block aligned. It also latches the game-logic sprite positions once per frame, so the picture never tears mid-frame.

---
 rtl/vga_sprite_render.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_render.sv
// -----------------------------------------------------------------------------
// vga_sprite_render
//
// Pixel-colour stage that sits directly after the 640x480@60 VGA timing
// generator. It draws two rectangular player sprites and a ground band over a
// flat background colour. Sprite positions, enables and colours are sampled
// once per frame, at the start of vertical blanking, so the picture never
// tears. Colour, blank and both syncs leave the block aligned, two clocks
// after the matching hcnt/vcnt value.
//
// Ports:
//   clk                  pixel clock (25 MHz), shared with the timing generator
//   reset                synchronous, active-high
//   hcnt, vcnt           pixel column / line from the timing generator
//   video_on             visible-area flag, aligned with hcnt/vcnt
//   hsync_in, vsync_in   active-low syncs, already one clock behind hcnt/vcnt
//   p1_*, p2_*           requested sprite position, enable and colour
//   rgb                  RGB888 pixel, zero outside the visible area
//   hsync_out, vsync_out active-low syncs aligned with rgb
//   blank_n              high while rgb carries a visible pixel
//   frame_tick           one-clock pulse when the sprite inputs are latched
// -----------------------------------------------------------------------------
module vga_sprite_render #(
    parameter int          SPR_W        = 64,
    parameter int          SPR_H        = 96,
    parameter int          GROUND_Y     = 440,
    parameter logic [23:0] BG_COLOR     = 24'h202040,
    parameter logic [23:0] GROUND_COLOR = 24'h406020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    input  logic        p1_en,
    input  logic        p2_en,
    input  logic [23:0] p1_color,
    input  logic [23:0] p2_color,
    output logic [23:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_n,
    output logic        frame_tick
);

    // Sprite extents and ground line widened to 11 bits so that x+SPR_W and
    // y+SPR_H never wrap back into the visible area.
    localparam logic [10:0] SPR_W_EXT    = 11'(SPR_W);
    localparam logic [10:0] SPR_H_EXT    = 11'(SPR_H);
    localparam logic [10:0] GROUND_Y_EXT = 11'(GROUND_Y);

    // Frame-latched copies of the game-logic inputs
    logic [9:0]  p1_x_r;
    logic [9:0]  p1_y_r;
    logic [9:0]  p2_x_r;
    logic [9:0]  p2_y_r;
    logic        p1_en_r;
    logic        p2_en_r;
    logic [23:0] p1_color_r;
    logic [23:0] p2_color_r;
    logic        frame_tick_r;

    // Stage 1 pipeline
    logic        hit1_r;
    logic        hit2_r;
    logic        gnd_r;
    logic        vis1_r;
    logic        hsync_r;
    logic        vsync_r;

    // Stage 2 pipeline
    logic [23:0] rgb_r;
    logic        blank_n_r;

    logic        latch_s;
    logic        hit1_s;
    logic        hit2_s;
    logic        gnd_s;
    logic [23:0] pix_s;

    // True when the counters sit on (h,v) inside an enabled sprite's box.
    function automatic logic sprite_hit(
        input logic       en,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] h,
        input logic [9:0] v
    );
        logic [10:0] h_ext;
        logic [10:0] v_ext;
        logic [10:0] x_ext;
        logic [10:0] y_ext;
        h_ext = {1'b0, h};
        v_ext = {1'b0, v};
        x_ext = {1'b0, x};
        y_ext = {1'b0, y};
        return en && (h_ext >= x_ext) && (h_ext < (x_ext + SPR_W_EXT)) &&
               (v_ext >= y_ext) && (v_ext < (y_ext + SPR_H_EXT));
    endfunction

    // Latch point: first blanking column of the last visible line.
    assign latch_s = (hcnt == 10'd640) && (vcnt == 10'd479);

    // Stage-1 combinational hit tests against the latched sprite state
    always_comb begin
        hit1_s = sprite_hit(p1_en_r, p1_x_r, p1_y_r, hcnt, vcnt);
        hit2_s = sprite_hit(p2_en_r, p2_x_r, p2_y_r, hcnt, vcnt);
        gnd_s  = ({1'b0, vcnt} >= GROUND_Y_EXT);
    end

    // Per-frame shadow registers and the frame_tick pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_x_r       <= 10'd0;
            p1_y_r       <= 10'd0;
            p2_x_r       <= 10'd0;
            p2_y_r       <= 10'd0;
            p1_en_r      <= 1'b0;
            p2_en_r      <= 1'b0;
            p1_color_r   <= 24'h000000;
            p2_color_r   <= 24'h000000;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= latch_s;
            if (latch_s) begin
                p1_x_r     <= p1_x;
                p1_y_r     <= p1_y;
                p2_x_r     <= p2_x;
                p2_y_r     <= p2_y;
                p1_en_r    <= p1_en;
                p2_en_r    <= p2_en;
                p1_color_r <= p1_color;
                p2_color_r <= p2_color;
            end
        end
    end

    // Stage 1 register; syncs arrive one clock late so they take one stage only
    always_ff @(posedge clk) begin
        if (reset) begin
            hit1_r  <= 1'b0;
            hit2_r  <= 1'b0;
            gnd_r   <= 1'b0;
            vis1_r  <= 1'b0;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else begin
            hit1_r  <= hit1_s;
            hit2_r  <= hit2_s;
            gnd_r   <= gnd_s;
            vis1_r  <= video_on;
            hsync_r <= hsync_in;
            vsync_r <= vsync_in;
        end
    end

    // Stage-2 colour priority: blanking, sprite 1, sprite 2, ground, background
    always_comb begin
        pix_s = BG_COLOR;
        if (!vis1_r) begin
            pix_s = 24'h000000;
        end else if (hit1_r) begin
            pix_s = p1_color_r;
        end else if (hit2_r) begin
            pix_s = p2_color_r;
        end else if (gnd_r) begin
            pix_s = GROUND_COLOR;
        end else begin
            pix_s = BG_COLOR;
        end
    end

    // Stage 2 register driving the colour and blank outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r     <= 24'h000000;
            blank_n_r <= 1'b0;
        end else begin
            rgb_r     <= pix_s;
            blank_n_r <= vis1_r;
        end
    end

    assign rgb        = rgb_r;
    assign blank_n    = blank_n_r;
    assign hsync_out  = hsync_r;
    assign vsync_out  = vsync_r;
    assign frame_tick = frame_tick_r;

endmodule
